tiny_cpu_sequencer: RTL and testbench

Program sequencer placed between the chip pins and `tiny_cpu`. It holds a small instruction buffer loaded over a byte-wide write port. It replays that buffer into the CPU instruction input one instruction per cycle, or one instruction per step pulse. It supports pause/resume, looping, a HALT encoding and an issued-instruction counter. It replaces hand-driven instruction streams on `ui_in` with a self-timed program run.

---
 rtl/tiny_cpu_pkg.sv | 15 +
 rtl/tiny_cpu_sequencer_prog_mem.sv | 26 ++
 rtl/tiny_cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_tiny_cpu_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared encodings and sequencer state type for tiny_cpu and its program sequencer.
package tiny_cpu_pkg;

   localparam int INSTR_W = 8;

   localparam logic [INSTR_W-1:0] INSTR_NOP  = 8'h00;
   localparam logic [INSTR_W-1:0] INSTR_HALT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/tiny_cpu_sequencer_prog_mem.sv
// Instruction buffer: DEPTH x INSTR_W array, synchronous write, asynchronous read.
// Latency: read is combinational; a write is visible after the writing edge.
// Backpressure: none; the caller gates the write enable.
module seq_prog_mem
   import tiny_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Replays a byte-loaded program into tiny_cpu, free-running or one instruction per step edge.
// Latency: run/step sampled at edge N puts mem[pc] on cpu_instr right after edge N.
// Backpressure: none; writes are dropped outside IDLE or when the buffer is full.
module tiny_cpu_sequencer
   import tiny_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [INSTR_W-1:0] prog_wdata,
   input  logic               prog_clr,
   input  logic               rewind,
   input  logic               run,
   input  logic               step,
   input  logic               loop_en,
   output logic [INSTR_W-1:0] cpu_instr,
   output logic [AW-1:0]      pc,
   output logic [1:0]         state,
   output logic               full,
   output logic [7:0]         issued_cnt
);

   seq_state_t         state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic [AW:0]        wptr_q, wptr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               step_q;
   logic               step_rise;
   logic               mem_we;
   logic               issue;
   logic               at_last;
   logic               has_prog;
   logic [INSTR_W-1:0] rd_instr;

   seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr_q[AW-1:0]),
      .wdata (prog_wdata),
      .raddr (pc_q),
      .rdata (rd_instr)
   );

   assign full      = (wptr_q == (AW+1)'(DEPTH));
   assign has_prog  = (wptr_q != '0);
   assign step_rise = step & ~step_q;
   assign at_last   = ({1'b0, pc_q} == (wptr_q - 1'b1));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wptr_d  = wptr_q;
      instr_d = INSTR_NOP;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      mem_we  = 1'b0;

      if (prog_clr) begin
         wptr_d  = '0;
         pc_d    = '0;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (rewind) begin
         pc_d    = '0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (prog_we) begin
                  mem_we = ~full;
               end else if (run && has_prog) begin
                  issue   = 1'b1;
                  state_d = RUN;
               end else if (step_rise && has_prog) begin
                  issue = 1'b1;
               end
            end
            RUN: begin
               if (run) issue = 1'b1;
               else     state_d = IDLE;
            end
            default: ;
         endcase
      end

      // HALT bytes stop the run in place; pc stays on the HALT so a resume cannot skip it
      if (issue) begin
         if (rd_instr == INSTR_HALT) begin
            state_d = HALT;
         end else begin
            instr_d = rd_instr;
            cnt_d   = cnt_q + 8'd1;
            if (at_last) begin
               if (loop_en) pc_d = '0;
               else         state_d = HALT;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
      end

      if (mem_we) wptr_d = wptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         wptr_q  <= '0;
         instr_q <= INSTR_NOP;
         cnt_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wptr_q  <= wptr_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         step_q  <= step;
      end
   end

   assign cpu_instr  = instr_q;
   assign pc         = pc_q;
   assign state      = state_q;
   assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Directed and randomized checks of tiny_cpu_sequencer against a queue-free behavioural model.
module tb_tiny_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       prog_we = 1'b0;
   logic [7:0] prog_wdata = 8'h00;
   logic       prog_clr = 1'b0;
   logic       rewind = 1'b0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       loop_en = 1'b0;
   logic [7:0] cpu_instr;
   logic [3:0] pc;
   logic [1:0] state;
   logic       full;
   logic [7:0] issued_cnt;

   int checks = 0;
   int failures = 0;

   // reference model: program image, length, cursor, mode (0 idle, 1 run, 2 halt)
   int m_mem [16];
   int m_len, m_pc, m_st, m_instr, m_cnt;
   bit m_stepq;

   tiny_cpu_sequencer #(.DEPTH(16), .AW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_wdata (prog_wdata),
      .prog_clr   (prog_clr),
      .rewind     (rewind),
      .run        (run),
      .step       (step),
      .loop_en    (loop_en),
      .cpu_instr  (cpu_instr),
      .pc         (pc),
      .state      (state),
      .full       (full),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_len = 0; m_pc = 0; m_st = 0; m_instr = 0; m_cnt = 0; m_stepq = 1'b0;
   endtask

   task automatic model_step();
      bit rise;
      bit go;
      rise    = step && !m_stepq;
      m_stepq = step;
      m_instr = 0;
      go      = 1'b0;
      if (prog_clr) begin
         m_len = 0; m_pc = 0; m_st = 0; m_cnt = 0;
      end else if (rewind) begin
         m_pc = 0; m_st = 0;
      end else if (m_st == 0) begin
         if (prog_we) begin
            if (m_len < 16) begin
               m_mem[m_len] = int'(prog_wdata);
               m_len++;
            end
         end else if (run && m_len > 0) begin
            go = 1'b1; m_st = 1;
         end else if (rise && m_len > 0) begin
            go = 1'b1;
         end
      end else if (m_st == 1) begin
         if (run) go = 1'b1;
         else     m_st = 0;
      end
      if (go) begin
         if (m_mem[m_pc] == 255) begin
            m_st = 2;
         end else begin
            m_instr = m_mem[m_pc];
            m_cnt   = (m_cnt + 1) % 256;
            if (m_pc == m_len - 1) begin
               if (loop_en) m_pc = 0;
               else         m_st = 2;
            end else begin
               m_pc++;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cpu_instr"}, {24'b0, cpu_instr}, 32'(m_instr));
      chk({tag, ".pc"}, {28'b0, pc}, 32'(m_pc));
      chk({tag, ".state"}, {30'b0, state}, 32'(m_st));
      chk({tag, ".full"}, {31'b0, full}, {31'b0, (m_len == 16)});
      chk({tag, ".issued_cnt"}, {24'b0, issued_cnt}, 32'(m_cnt));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic load(input logic [7:0] b);
      prog_we = 1'b1; prog_wdata = b;
      tick("load");
      prog_we = 1'b0;
   endtask

   task automatic pulse_clr();
      prog_clr = 1'b1; tick("clr"); prog_clr = 1'b0;
   endtask

   task automatic pulse_rewind();
      rewind = 1'b1; tick("rewind"); rewind = 1'b0;
   endtask

   initial begin
      // reset held for two cycles
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // run with an empty program does nothing
      run = 1'b1;
      tick("empty_run");
      tick("empty_run");
      chk("empty_state_idle", {30'b0, state}, 32'd0);
      run = 1'b0;

      // straight-line program halts after the last instruction
      load(8'h21); load(8'h31); load(8'h42);
      loop_en = 1'b0; run = 1'b1;
      tick("seq0"); chk("seq0_first", {24'b0, cpu_instr}, 32'h21);
      tick("seq1");
      tick("seq2"); chk("seq2_last", {24'b0, cpu_instr}, 32'h42);
      tick("seq_end");
      chk("seq_halt_state", {30'b0, state}, 32'd2);
      chk("seq_halt_pc", {28'b0, pc}, 32'd2);
      chk("seq_halt_cnt", {24'b0, issued_cnt}, 32'd3);
      tick("seq_hold");
      run = 1'b0;
      pulse_rewind();
      chk("rewind_pc", {28'b0, pc}, 32'd0);

      // looping, pause and resume
      loop_en = 1'b1; run = 1'b1;
      repeat (3) tick("loop");
      run = 1'b0;
      tick("pause"); chk("pause_nop", {24'b0, cpu_instr}, 32'h00);
      tick("paused");
      run = 1'b1;
      tick("resume"); chk("resume_first", {24'b0, cpu_instr}, 32'h21);
      repeat (6) tick("loop2");
      run = 1'b0; loop_en = 1'b0;
      tick("stop");
      pulse_rewind();

      // stepping: one instruction per rising edge of step
      for (int p = 0; p < 3; p++) begin
         step = 1'b1;
         repeat (3) tick("step_hi");
         step = 1'b0;
         repeat (2) tick("step_lo");
      end
      chk("step_end_halt", {30'b0, state}, 32'd2);

      // embedded HALT byte
      pulse_clr();
      load(8'h21); load(8'hFF); load(8'h31);
      run = 1'b1;
      tick("hb0"); tick("hb1"); tick("hb2");
      chk("hb_pc", {28'b0, pc}, 32'd1);
      chk("hb_cnt", {24'b0, issued_cnt}, 32'd1);
      run = 1'b0;

      // fill to capacity, write while full and while running
      pulse_clr();
      for (int i = 0; i < 17; i++) load(8'(i + 1));
      chk("full_after_17", {31'b0, full}, 32'd1);
      run = 1'b1;
      tick("full_run");
      prog_we = 1'b1; prog_wdata = 8'h55;
      repeat (3) tick("we_in_run");
      prog_we = 1'b0;
      repeat (14) tick("full_run2");
      run = 1'b0;
      pulse_clr();
      chk("clr_full", {31'b0, full}, 32'd0);
      chk("clr_cnt", {24'b0, issued_cnt}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         prog_clr   = ($urandom_range(0, 99) < 2);
         rewind     = ($urandom_range(0, 99) < 4);
         prog_we    = ($urandom_range(0, 99) < 25);
         prog_wdata = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 7) == 0) run = ~run;
         if ($urandom_range(0, 2) == 0) step = ~step;
         if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
         tick("rand");
      end
      prog_clr = 1'b0; rewind = 1'b0; prog_we = 1'b0; run = 1'b0; step = 1'b0;

      // asynchronous reset in the middle of a looping run
      pulse_clr();
      load(8'h11); load(8'h22);
      loop_en = 1'b1; run = 1'b1;
      repeat (3) tick("pre_arst");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
